pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DW, default 32, meaning payload width in bits (DW >= 1).
REQ-002 SHALL have parameter BUBBLE, DW bits wide, default 0, meaning the out_data value driven whenever no valid payload is held.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all held payloads (pipeline kill).
REQ-006 SHALL have port in_valid, input, 1, upstream payload present.
REQ-007 SHALL have port in_ready, output, 1, block can accept a payload this cycle.
REQ-008 SHALL have port in_data, input, DW, upstream payload.
REQ-009 SHALL have port out_valid, output, 1, downstream payload present.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the payload this cycle.
REQ-011 SHALL have port out_data, output, DW, downstream payload.
REQ-012 SHALL have port count, output, 2, number of held payloads (0..2).

Function
REQ-013 SHALL hold a main register M (drives out_data) and a skid register S, with states EMPTY (count 0), ONE (M valid), and FULL (M and S valid).
REQ-014 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready, both sampled at the clock edge.
REQ-015 SHALL drive out_valid = (state != EMPTY) and in_ready = (state != FULL), both decoded from registered state only, with no combinational path from out_ready or in_valid to any output.
REQ-016 SHALL in EMPTY: on in_fire go to ONE with M <= in_data; otherwise stay EMPTY.
REQ-017 SHALL in ONE: on in_fire & out_fire stay ONE with M <= in_data; on in_fire & !out_fire go to FULL with S <= in_data and M unchanged; on out_fire only go to EMPTY with M <= BUBBLE; on neither, hold.
REQ-018 SHALL in FULL: on out_fire go to ONE with M <= S and S <= BUBBLE; otherwise hold (in_ready = 0, so no input is accepted).
REQ-019 SHALL keep out_data and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-020 SHALL drive out_data = BUBBLE whenever out_valid = 0.
REQ-021 SHALL deliver payloads in acceptance order with no loss or duplication; latency from in_fire to out_valid is 1 cycle when EMPTY.
REQ-022 SHALL sustain one transfer per cycle when out_ready is held at 1.
REQ-023 SHALL on flush = 1 go to EMPTY with M, S <= BUBBLE and count <= 0, discard any simultaneous in_fire, and make no state change for a simultaneous out_fire (the consumer samples out_data that cycle; the flush kills only what remains).
REQ-024 SHALL give rst priority over flush, and flush priority over all handshake transitions.
REQ-025 SHALL keep count consistent with state: EMPTY = 0, ONE = 1, FULL = 2; count = 3 never occurs.

Reset
REQ-026 SHALL on rst = 1 at a clock edge set state EMPTY, M = S = BUBBLE, out_valid = 0, in_ready = 1, count = 0, out_data = BUBBLE, regardless of any other input.
REQ-027 SHALL drop any payload held or offered during a reset asserted mid-operation; the first in_fire after rst deasserts is the first payload output.

Verification
REQ-028 SHALL pass this scenario: after reset, in_valid = 1 with data 0xA5, out_ready = 1 -> next cycle out_valid = 1, out_data = 0xA5, count = 1.
REQ-029 SHALL pass this scenario: out_ready = 0, push 0x11 then 0x22 -> count = 2, in_ready = 0, out_data = 0x11 held; then out_ready = 1 for 2 cycles -> 0x11 then 0x22 out, count 0, out_data = BUBBLE.
REQ-030 SHALL pass this scenario: streaming 0..99 with out_ready = 1 constantly -> 100 outputs in order on consecutive cycles, count stays 1, in_ready stays 1.
REQ-031 SHALL pass this scenario: random in_valid and out_ready at 50% each over 10k cycles -> scoreboard order match, no out_data change while stalled, and in_ready/out_valid never depend combinationally on same-cycle inputs.
REQ-032 SHALL pass this scenario: FULL with 0x33/0x44, flush = 1 with in_valid = 1 data 0x55 -> next cycle count = 0, out_valid = 0, out_data = BUBBLE, and 0x55 never appears.
REQ-033 SHALL pass this scenario: rst and flush asserted together in state ONE with BUBBLE = 0xDEADBEEF -> reset values per REQ-026 and out_data = 0xDEADBEEF.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Registered pipeline stage with a one-entry skid buffer. out_valid and in_ready
// come only from registered state, so the stage fully cuts both handshake paths.
module pipe_skid_reg #(
    parameter int unsigned     DW     = 32,
    parameter logic [DW-1:0]   BUBBLE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);

    // Encoding doubles as the held-payload count, so count is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] m_q, m_d;
    logic [DW-1:0] s_q, s_d;
    logic          in_fire;
    logic          out_fire;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_FULL);
    assign out_data  = m_q;
    assign count     = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            state_d = ST_EMPTY;
            m_d     = BUBBLE;
            s_d     = BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        m_d     = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        m_d = in_data;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        s_d     = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        m_d     = BUBBLE;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        m_d     = s_q;
                        s_d     = BUBBLE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    m_d     = BUBBLE;
                    s_d     = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            m_q     <= BUBBLE;
            s_q     <= BUBBLE;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, in-order streaming, and a
// randomized run against a queue-based model of held payloads.
module tb_pipe_skid_reg;

    localparam int unsigned   DW = 32;
    localparam logic [DW-1:0] B  = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    count;

    int total = 0;
    int bad   = 0;

    // Model: payloads accepted but not yet delivered, oldest at the front.
    logic [DW-1:0] exp_q[$];

    pipe_skid_reg #(.DW(DW), .BUBBLE(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          flush;
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic          e_ir;
        logic [1:0]    e_cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, clock, then settle 1 time unit.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [DW-1:0] id, input logic ordy);
        int unsigned n;
        bit in_f, out_f;
        rst = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
        n     = exp_q.size();
        in_f  = iv && (n < 2);
        out_f = ordy && (n > 0);
        @(posedge clk);
        if (r || f) begin
            exp_q.delete();
        end else begin
            if (out_f) void'(exp_q.pop_front());
            if (in_f) exp_q.push_back(id);
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        int unsigned n;
        n = exp_q.size();
        chk({tag, ".out_valid"}, DW'(out_valid), DW'(n > 0));
        chk({tag, ".out_data"}, out_data, (n > 0) ? exp_q[0] : B);
        chk({tag, ".in_ready"}, DW'(in_ready), DW'(n < 2));
        chk({tag, ".count"}, DW'(count), DW'(n));
    endtask

    initial begin
        logic          p_ov, p_ordy, p_hold;
        logic [DW-1:0] p_od;
        logic          c_ov, c_ir;
        logic [DW-1:0] c_od;
        logic [1:0]    c_cnt;
        logic          r, f, iv, ordy;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        //          rst   flush iv    data   ordy  e_ov  e_od   e_ir  cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, B,     1'b1, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'hA5, 1'b1, 1'b1, 32'hA5, 1'b1, 2'd1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, B,     1'b1, 2'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 1'b1, 2'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 1'b0, 2'd2};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h99, 1'b0, 1'b1, 32'h11, 1'b0, 2'd2};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h22, 1'b1, 2'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, B,     1'b1, 2'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 32'h33, 1'b1, 2'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 32'h33, 1'b0, 2'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h55, 1'b0, 1'b0, B,     1'b1, 2'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, B,     1'b1, 2'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h66, 1'b0, 1'b1, 32'h66, 1'b1, 2'd1};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h77, 1'b1, 1'b0, B,     1'b1, 2'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h88, 1'b1, 1'b1, 32'h88, 1'b1, 2'd1};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h99, 1'b1, 1'b0, B,     1'b1, 2'd0};

        for (int i = 0; i < 16; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            chk({tag, ".out_valid"}, DW'(out_valid), DW'(vecs[i].e_ov));
            chk({tag, ".out_data"}, out_data, vecs[i].e_od);
            chk({tag, ".in_ready"}, DW'(in_ready), DW'(vecs[i].e_ir));
            chk({tag, ".count"}, DW'(count), DW'(vecs[i].e_cnt));
        end

        // Streaming: one transfer per cycle, one cycle latency, in order.
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, 1'b1, DW'(i), 1'b1);
            chk("stream.data", out_data, DW'(i));
            chk("stream.count", DW'(count), DW'(1));
            chk("stream.in_ready", DW'(in_ready), DW'(1));
        end
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk_model("stream_drain");
        chk("stream_drain.bubble", out_data, B);

        // Randomized run with occasional flush/reset.
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk_model("rand_reset");
        for (int cyc = 0; cyc < 10000; cyc++) begin
            r    = ($urandom_range(0, 999) == 0);
            f    = ($urandom_range(0, 99) == 0);
            iv   = $urandom_range(0, 1) == 1;
            ordy = $urandom_range(0, 1) == 1;
            p_ov = out_valid; p_od = out_data; p_ordy = ordy;
            p_hold = p_ov && !p_ordy && !r && !f;

            // Outputs must not move when same-cycle inputs toggle.
            rst = r; flush = f; in_valid = iv; in_data = $urandom; out_ready = ordy;
            #1;
            c_ov = out_valid; c_ir = in_ready; c_od = out_data; c_cnt = count;
            in_valid = ~iv; out_ready = ~ordy; flush = ~f;
            #1;
            chk("comb_path", {c_ov, c_ir, c_cnt, c_od[27:0]},
                {out_valid, in_ready, count, out_data[27:0]});

            step(r, f, iv, in_data, ordy);
            chk_model($sformatf("rand%0d", cyc));
            if (p_hold) begin
                chk("stall.hold_data", out_data, p_od);
                chk("stall.hold_valid", DW'(out_valid), DW'(1));
            end
        end

        // Drain remaining payloads and confirm the model empties with the DUT.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, '0, 1'b1);
            chk_model("final_drain");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
